mm_exec: RTL
============

Name: mm_exec

Overview:
- Command-driven execute sequencer that sits directly upstream of the mm memory block and is its only master.
- Each accepted command drives mm's two async read ports to fetch operands A and B, computes an ALU result, then drives mm's sync write port to store the result.
- Fixed 3-cycle command latency; status flags and a done pulse go back to the issuing control logic.

Parameters:
- WORD_W, 8, data word width; must match mm WORD_W.
- ADDR_W, 4, memory address width; must match mm ADDR_W.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MOV, 7 LDI
- cmd_src_a  in  ADDR_W  operand A address
- cmd_src_b  in  ADDR_W  operand B address
- cmd_dst  in  ADDR_W  result address
- cmd_imm  in  WORD_W  immediate, used by LDI only
- raddr0  out  ADDR_W  to mm raddr0
- rdata0  in  WORD_W  from mm rdata0
- raddr1  out  ADDR_W  to mm raddr1
- rdata1  in  WORD_W  from mm rdata1
- we  out  1  to mm we
- waddr  out  ADDR_W  to mm waddr
- wdata  out  WORD_W  to mm wdata
- done  out  1  one-cycle pulse, coincident with the write cycle
- busy  out  1  high whenever state is not IDLE
- flag_z  out  1  result of last completed command == 0
- flag_c  out  1  carry (ADD), borrow (SUB), or shifted-out MSB (SHL); 0 for other ops

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0 except cmd_ready=1; latched command and operand registers 0.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/src_a/src_b/dst/imm and go to READ.
  - READ: raddr0=src_a, raddr1=src_b, both driven from registers. Capture rdata0->opA and rdata1->opB at the end of the cycle. Go to WB.
  - WB: we=1, waddr=dst, wdata=result, done=1. flag_z and flag_c update at the end of this cycle. Go to IDLE.
- Latency: command accepted at edge N; operands read during cycle N+1; write and done during cycle N+2. Next accept earliest at edge N+3. Throughput is 1 command per 3 cycles.
- Outputs outside WB: cmd_ready=0 in READ and WB. we, done and wdata are 0 outside WB. raddr0/raddr1 hold their last value outside READ.
- ALU semantics (all mod 2^WORD_W):
  - ADD: A+B; c = bit WORD_W of the sum.
  - SUB: A-B; c=1 iff A<B unsigned.
  - AND, OR, XOR: bitwise.
  - SHL: A<<1; c=A[MSB].
  - MOV: A.
  - LDI: imm; the read still occurs and is ignored.
- The result is computed combinationally from opA/opB/op in WB. No division, no signed arithmetic.
- Aliasing: dst may equal src_a and/or src_b. Operands are captured in READ, before the write in WB, so the old value is used. The mm write-bypass path is never exercised by this block.
- Address wrap: addresses are taken as-is. No range check is needed, since ADDR_W covers the full memory.
- cmd_valid asserted while busy is ignored; the command is not latched and the source must hold it. Command fields are sampled only at accept.
- Reset mid-operation: we, done and busy drop to 0 immediately (async). A command in READ or WB is discarded and no write occurs. Flags return to 0.
- cmd_valid low in IDLE: remain in IDLE with no outputs toggling.

Decomposition:
- Shared package mm_pkg: opcode localparams (OP_ADD..OP_LDI), FSM state encodings (S_IDLE, S_READ, S_WB), and the default WORD_W/ADDR_W.
- One natural sub-module: mm_alu, purely combinational. Inputs op, a, b, imm; outputs result, carry, zero. It is instantiated once in mm_exec.
- Bench top instantiates mm_exec connected to mm.

Test Plan:
- Reset then LDI dst=3 imm=0x5A -> accept at edge N, we=1, waddr=3, wdata=0x5A, done=1 in cycle N+2; flag_z=0; mm[3]=0x5A after that edge.
- LDI mem[1]=0xF0, LDI mem[2]=0x20, then ADD a=1 b=2 dst=4 -> wdata=0x10, flag_c=1, flag_z=0; SUB a=2 b=1 dst=5 -> 0x30, flag_c=1.
- XOR a=1 b=1 dst=1 (full aliasing) -> wdata=0x00, flag_z=1, mm[1]=0; a following MOV a=1 dst=6 writes 0x00.
- cmd_valid held high with 3 back-to-back commands -> cmd_ready low in READ/WB, accepts exactly every 3rd edge, 3 done pulses, no command dropped or duplicated.
- SHL a=1 with mem[1]=0x81 -> wdata=0x02, flag_c=1; AND 0x0F&0xF0 -> 0x00, flag_z=1, flag_c=0.
- Assert rst_n low during WB of ADD dst=7 -> we falls immediately, mm[7] unchanged, cmd_ready=1 and busy=0 after release.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the mm execute sequencer: default widths, opcodes
// and FSM state encodings.
package mm_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/mm_alu.sv
// Combinational ALU for mm_exec: unsigned arithmetic/logic on two operands,
// with carry/borrow/shift-out flag and zero detect.
module mm_alu
  import mm_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] imm,
  output logic [WORD_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [WORD_W:0] sum;
  logic [WORD_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // top bit of the widened difference is the borrow, set exactly when a < b
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WORD_W-1:0];
        carry  = sum[WORD_W];
      end
      OP_SUB: begin
        result = diff[WORD_W-1:0];
        carry  = diff[WORD_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[WORD_W-2:0], 1'b0};
        carry  = a[WORD_W-1];
      end
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mm_exec.sv
// Command-driven execute sequencer and sole master of the mm memory:
// IDLE accepts a command, READ fetches both operands, WB writes the result.
module mm_exec
  import mm_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [WORD_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] raddr0,
  input  logic [WORD_W-1:0] rdata0,
  output logic [ADDR_W-1:0] raddr1,
  input  logic [WORD_W-1:0] rdata1,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              done,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c
);

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic [WORD_W-1:0] imm_q;
  logic [WORD_W-1:0] opa_q;
  logic [WORD_W-1:0] opb_q;

  logic [WORD_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              accept;

  mm_alu #(.WORD_W(WORD_W)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    we        = 1'b0;
    done      = 1'b0;
    waddr     = '0;
    wdata     = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = S_READ;
      end
      S_READ: state_nxt = S_WB;
      S_WB: begin
        we        = 1'b1;
        done      = 1'b1;
        waddr     = dst_q;
        wdata     = alu_result;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      src_a_q <= cmd_src_a;
      src_b_q <= cmd_src_b;
      dst_q   <= cmd_dst;
      imm_q   <= cmd_imm;
    end
  end

  // Operands are captured before WB, so dst aliasing a source sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state == S_READ) begin
      opa_q <= rdata0;
      opb_q <= rdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state == S_WB) begin
      flag_z <= alu_zero;
      flag_c <= alu_carry;
    end
  end

  // Source registers only change at accept, so they hold their value outside READ.
  assign raddr0 = src_a_q;
  assign raddr1 = src_b_q;

endmodule
